// File: rtl/l1_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the L1 memory arbiter slice:
//   - arbiter FSM state encoding (IDLE=0 .. DONE=4)
//   - client id encoding (CL_IC, CL_DC)
//   - line / beat geometry and the line-offset width
// Optional feature macro used by the arbiter: MEM_ARB_RR_EN.
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 32;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int LINE_OFFS_W = 5;
    localparam int CNT_W       = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WBEAT = 3'd2,
        RBEAT = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        CL_IC = 1'b0,
        CL_DC = 1'b1
    } client_t;

endpackage

// File: rtl/l1_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// l1_mem_arbiter_if
// Bundles the cache-side request/response signals and the main-memory port.
//   Cache side : ic_read_*, dc_read_*, dc_write_*
//   Memory side: mem_cmd_*, mem_wdata*, mem_rdata*
// Modports:
//   slave  - the arbiter (serves the caches, drives the memory port)
//   master - the environment (caches + memory model)
//
// Handshake rules: a *_req is held by the cache until its *_valid pulse, which
// lasts exactly one cycle. On the memory port a command or write beat transfers
// on the rising edge where its valid and the matching ready are both high; the
// arbiter holds valid and payload stable until then. mem_rdata_valid has no
// ready: every read beat is taken when it is offered.
// ----------------------------------------------------------------------------
interface l1_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32
);
    logic              ic_read_req;
    logic [ADDR_W-1:0] ic_read_addr;
    logic [LINE_W-1:0] ic_read_data;
    logic              ic_read_valid;

    logic              dc_read_req;
    logic [ADDR_W-1:0] dc_read_addr;
    logic [LINE_W-1:0] dc_read_data;
    logic              dc_read_valid;

    logic              dc_write_req;
    logic [ADDR_W-1:0] dc_write_addr;
    logic [LINE_W-1:0] dc_write_data;
    logic              dc_write_valid;

    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_write;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [BEAT_W-1:0] mem_wdata;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_rdata_valid;

    modport slave (
        input  ic_read_req, ic_read_addr,
        input  dc_read_req, dc_read_addr,
        input  dc_write_req, dc_write_addr, dc_write_data,
        input  mem_cmd_ready, mem_wdata_ready, mem_rdata, mem_rdata_valid,
        output ic_read_data, ic_read_valid,
        output dc_read_data, dc_read_valid, dc_write_valid,
        output mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
        output mem_wdata, mem_wdata_valid
    );

    modport master (
        output ic_read_req, ic_read_addr,
        output dc_read_req, dc_read_addr,
        output dc_write_req, dc_write_addr, dc_write_data,
        output mem_cmd_ready, mem_wdata_ready, mem_rdata, mem_rdata_valid,
        input  ic_read_data, ic_read_valid,
        input  dc_read_data, dc_read_valid, dc_write_valid,
        input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
        input  mem_wdata, mem_wdata_valid
    );

endinterface

// File: rtl/l1_mem_arbiter_line_beat_mux.sv
// ----------------------------------------------------------------------------
// line_beat_mux
// Word-level access into a cache line. Word 0 is the most significant beat
// (bits [LINE_W-1 -: BEAT_W]), the last word is bits [BEAT_W-1:0].
// Ports:
//   i_line    - current line buffer
//   i_rd_sel  - word index to read out          -> o_rd_word
//   i_wr_sel  - word index to overwrite with i_wr_word -> o_line_wr
// Purely combinational.
// ----------------------------------------------------------------------------
module line_beat_mux #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32,
    parameter int SEL_W  = 3
) (
    input  logic [LINE_W-1:0] i_line,
    input  logic [SEL_W-1:0]  i_rd_sel,
    output logic [BEAT_W-1:0] o_rd_word,
    input  logic [SEL_W-1:0]  i_wr_sel,
    input  logic [BEAT_W-1:0] i_wr_word,
    output logic [LINE_W-1:0] o_line_wr
);
    localparam int BEATS = LINE_W / BEAT_W;

    always_comb begin
        o_rd_word = '0;
        o_line_wr = i_line;
        for (int k = 0; k < BEATS; k++) begin
            if (i_rd_sel == SEL_W'(k)) begin
                o_rd_word = i_line[LINE_W-1-k*BEAT_W -: BEAT_W];
            end
            if (i_wr_sel == SEL_W'(k)) begin
                o_line_wr[LINE_W-1-k*BEAT_W -: BEAT_W] = i_wr_word;
            end
        end
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// ----------------------------------------------------------------------------
// l1_mem_arbiter
// Arbitrates icache fills, dcache fills and dcache write-backs onto a single
// 32-bit memory port. Each granted request becomes one command followed by an
// 8-beat burst; read bursts are reassembled into a line returned with a
// one-cycle valid pulse.
// Ports:
//   CLK, RESET  - clock, asynchronous active-low reset
//   bus         - l1_mem_arbiter_if.slave (cache requests + memory port)
//   o_dbg_state - current FSM state (mem_arb_pkg::state_t encoding)
// Config macro MEM_ARB_RR_EN: round-robin between the two readers (pointer
// starts at the dcache, moves to the other reader after each completed read).
// Without it the dcache read always beats the icache read. Write-back always
// has top priority.
// ----------------------------------------------------------------------------
module l1_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    l1_mem_arbiter_if.slave        bus,
    output logic [2:0]             o_dbg_state
);
    import mem_arb_pkg::*;

    localparam int BEATS_L = LINE_W / BEAT_W;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << LINE_OFFS_W) - 1);

    state_t              r_state;
    client_t             r_client;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [LINE_W-1:0]   r_line;
    logic                r_cmd_valid;
    logic                r_cmd_write;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [BEAT_W-1:0]   r_wdata;
    logic                r_wdata_valid;
    logic                r_ic_valid;
    logic                r_dc_valid;
    logic                r_wr_valid;
    logic [LINE_W-1:0]   r_ic_data;
    logic [LINE_W-1:0]   r_dc_data;
`ifdef MEM_ARB_RR_EN
    client_t             r_rr_ptr;
`endif

    logic                w_gnt_any;
    logic                w_gnt_wr;
    client_t             w_gnt_cl;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic                w_cmd_fire;
    logic                w_wbeat_fire;
    logic                w_last_beat;
    logic [CNT_W-1:0]    w_rd_sel;
    logic [BEAT_W-1:0]   w_rd_word;
    logic [LINE_W-1:0]   w_line_wr;

    // Grant selection, only acted on in IDLE.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_wr  = 1'b0;
        w_gnt_cl  = CL_DC;
        if (bus.dc_write_req) begin
            w_gnt_any = 1'b1;
            w_gnt_wr  = 1'b1;
        end else if (bus.dc_read_req && bus.ic_read_req) begin
            w_gnt_any = 1'b1;
`ifdef MEM_ARB_RR_EN
            w_gnt_cl  = r_rr_ptr;
`else
            w_gnt_cl  = CL_DC;
`endif
        end else if (bus.dc_read_req) begin
            w_gnt_any = 1'b1;
        end else if (bus.ic_read_req) begin
            w_gnt_any = 1'b1;
            w_gnt_cl  = CL_IC;
        end
    end

    assign w_gnt_addr   = (w_gnt_cl == CL_IC) ? bus.ic_read_addr
                        : (w_gnt_wr ? bus.dc_write_addr : bus.dc_read_addr);
    assign w_cmd_fire   = r_cmd_valid & bus.mem_cmd_ready;
    assign w_wbeat_fire = r_wdata_valid & bus.mem_wdata_ready;
    assign w_last_beat  = (r_beat_cnt == CNT_W'(BEATS_L - 1));

    // mem_wdata is registered, so the mux looks one word ahead: word 0 while
    // the command is pending, word beat_cnt+1 while beats are being accepted.
    assign w_rd_sel = (r_state == WBEAT) ? (r_beat_cnt + CNT_W'(1)) : '0;

    line_beat_mux #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .SEL_W  (CNT_W)
    ) u_line_beat_mux (
        .i_line    (r_line),
        .i_rd_sel  (w_rd_sel),
        .o_rd_word (w_rd_word),
        .i_wr_sel  (r_beat_cnt),
        .i_wr_word (bus.mem_rdata),
        .o_line_wr (w_line_wr)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= IDLE;
            r_client      <= CL_IC;
            r_beat_cnt    <= '0;
            r_line        <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_write   <= 1'b0;
            r_cmd_addr    <= '0;
            r_wdata       <= '0;
            r_wdata_valid <= 1'b0;
            r_ic_valid    <= 1'b0;
            r_dc_valid    <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_ic_data     <= '0;
            r_dc_data     <= '0;
`ifdef MEM_ARB_RR_EN
            r_rr_ptr      <= CL_DC;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_client    <= w_gnt_cl;
                        r_cmd_write <= w_gnt_wr;
                        r_cmd_addr  <= w_gnt_addr & ADDR_MASK;
                        r_cmd_valid <= 1'b1;
                        r_beat_cnt  <= '0;
                        if (w_gnt_wr) begin
                            r_line <= bus.dc_write_data;
                        end
                        r_state <= CMD;
                    end
                end
                CMD: begin
                    if (w_cmd_fire) begin
                        r_cmd_valid <= 1'b0;
                        if (r_cmd_write) begin
                            r_wdata_valid <= 1'b1;
                            r_wdata       <= w_rd_word;
                            r_state       <= WBEAT;
                        end else begin
                            r_state <= RBEAT;
                        end
                    end
                end
                WBEAT: begin
                    if (w_wbeat_fire) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        if (w_last_beat) begin
                            r_wdata_valid <= 1'b0;
                            r_wr_valid    <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_wdata <= w_rd_word;
                        end
                    end
                end
                RBEAT: begin
                    if (bus.mem_rdata_valid) begin
                        r_line     <= w_line_wr;
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        if (w_last_beat) begin
                            // Output data registers take the completed line
                            // directly so it lines up with the valid pulse.
                            if (r_client == CL_DC) begin
                                r_dc_data  <= w_line_wr;
                                r_dc_valid <= 1'b1;
                            end else begin
                                r_ic_data  <= w_line_wr;
                                r_ic_valid <= 1'b1;
                            end
`ifdef MEM_ARB_RR_EN
                            r_rr_ptr <= (r_client == CL_DC) ? CL_IC : CL_DC;
`endif
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_ic_valid <= 1'b0;
                    r_dc_valid <= 1'b0;
                    r_wr_valid <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cmd_valid   = r_cmd_valid;
    assign bus.mem_cmd_write   = r_cmd_write;
    assign bus.mem_cmd_addr    = r_cmd_addr;
    assign bus.mem_wdata       = r_wdata;
    assign bus.mem_wdata_valid = r_wdata_valid;
    assign bus.ic_read_data    = r_ic_data;
    assign bus.ic_read_valid   = r_ic_valid;
    assign bus.dc_read_data    = r_dc_data;
    assign bus.dc_read_valid   = r_dc_valid;
    assign bus.dc_write_valid  = r_wr_valid;
    assign o_dbg_state         = r_state;

endmodule
